// File: rtl/adc_vdc_acq_pkg.sv
// Shared constants and FSM encoding for the DC-link voltage acquisition block.
// Voltages are signed Q20.17; ADC frames are 16 bits carrying a 12-bit code.
package adc_vdc_acq_pkg;

    localparam int BITS_ENTEROS   = 20;
    localparam int BITS_DECIMAL   = 17;
    localparam int VDC_W          = BITS_ENTEROS + BITS_DECIMAL + 1;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_CODE_BITS  = 12;
    localparam int DIFF_W         = ADC_CODE_BITS + 1;
    localparam int GAIN_W         = 24;
    localparam int PROD_W         = DIFF_W + GAIN_W;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        SCALE,
        UPDATE
    } state_t;

endpackage

// File: rtl/adc_vdc_acq_scale.sv
// One channel of code-to-volts conversion: offset removal, gain multiply and
// over-voltage compare. Product is registered when en is high.
module adc_vdc_acq_scale
    import adc_vdc_acq_pkg::*;
#(
    parameter int unsigned OFFSET   = 0,
    parameter int unsigned GAIN_Q17 = 12800,
    parameter int          VMAX_Q17 = 45875200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADC_CODE_BITS-1:0] code,
    output logic signed [PROD_W-1:0] prod,
    output logic                     over
);

    localparam logic signed [DIFF_W-1:0] OFF_S  = DIFF_W'(OFFSET);
    localparam logic signed [PROD_W-1:0] GAIN_S = PROD_W'(GAIN_Q17);
    localparam logic signed [VDC_W-1:0]  VMAX_S = VDC_W'(VMAX_Q17);

    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] prod_c;

    assign diff   = $signed({1'b0, code}) - OFF_S;
    assign diff_x = {{GAIN_W{diff[DIFF_W-1]}}, diff};
    assign prod_c = diff_x * GAIN_S;
    // compare the value as it will appear on the wider Vdc output
    assign over   = $signed({prod_c[PROD_W-1], prod_c}) > VMAX_S;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prod <= '0;
        else if (en)
            prod <= prod_c;
    end

endmodule

// File: rtl/adc_vdc_acq.sv
// Reads both DC-link ADCs once per trigger over a shared SCLK/CS bus and
// presents the scaled Q20.17 voltages plus sticky overrun/over-voltage flags.
module adc_vdc_acq
    import adc_vdc_acq_pkg::*;
#(
    parameter int          CLK_DIV  = 2,
    parameter int unsigned OFFSET   = 0,
    parameter int unsigned GAIN_Q17 = 12800,
    parameter int          VMAX_Q17 = 45875200
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CE,
    input  logic                    trigger,
    input  logic                    adc_sdata1,
    input  logic                    adc_sdata2,
    output logic                    adc_sclk,
    output logic                    adc_cs_n,
    output logic signed [VDC_W-1:0] Vdc1,
    output logic signed [VDC_W-1:0] Vdc2,
    output logic                    valid,
    output logic                    busy,
    output logic                    overrun,
    output logic [1:0]              vdc_fault
);

    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam int BW = $clog2(ADC_FRAME_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] RISE      = CW'(CLK_DIV);
    localparam logic [CW-1:0] PER_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(ADC_FRAME_BITS - 1);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bitcnt;
    // only the low code bits are kept; the leading frame bits fall off the top
    logic [ADC_CODE_BITS-1:0] sr1, sr2;
    logic signed [PROD_W-1:0] prod1, prod2;
    logic over1, over2;
    logic scale_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (CE)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (trigger) nxt = SETUP;
            SETUP:   if (cnt == HALF_LAST) nxt = SHIFT;
            SHIFT:   if (cnt == PER_LAST && bitcnt == BIT_LAST) nxt = HOLD;
            HOLD:    if (cnt == HALF_LAST) nxt = SCALE;
            SCALE:   nxt = UPDATE;
            UPDATE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        adc_cs_n = !(state == SETUP || state == SHIFT);
        adc_sclk = !(state == SHIFT && cnt <= HALF_LAST);
        valid    = (state == UPDATE);
        busy     = (state != IDLE);
        scale_en = CE && (state == SCALE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bitcnt    <= '0;
            sr1       <= '0;
            sr2       <= '0;
            overrun   <= 1'b0;
            vdc_fault <= 2'b00;
        end else if (CE) begin
            if (trigger && state != IDLE)
                overrun <= 1'b1;
            case (state)
                SETUP, HOLD: cnt <= (cnt == HALF_LAST) ? '0 : cnt + CW'(1);
                SHIFT:       cnt <= (cnt == PER_LAST)  ? '0 : cnt + CW'(1);
                default:     cnt <= '0;
            endcase
            if (state == SHIFT) begin
                // sample on the first cycle of the SCLK high half
                if (cnt == RISE) begin
                    sr1 <= {sr1[ADC_CODE_BITS-2:0], adc_sdata1};
                    sr2 <= {sr2[ADC_CODE_BITS-2:0], adc_sdata2};
                end
                if (cnt == PER_LAST)
                    bitcnt <= bitcnt + BW'(1);
            end else begin
                bitcnt <= '0;
            end
            if (state == SCALE)
                vdc_fault <= vdc_fault | {over2, over1};
        end
    end

    adc_vdc_acq_scale #(.OFFSET(OFFSET), .GAIN_Q17(GAIN_Q17), .VMAX_Q17(VMAX_Q17)) u_scale1 (
        .clk  (clk),
        .rst  (rst),
        .en   (scale_en),
        .code (sr1),
        .prod (prod1),
        .over (over1)
    );

    adc_vdc_acq_scale #(.OFFSET(OFFSET), .GAIN_Q17(GAIN_Q17), .VMAX_Q17(VMAX_Q17)) u_scale2 (
        .clk  (clk),
        .rst  (rst),
        .en   (scale_en),
        .code (sr2),
        .prod (prod2),
        .over (over2)
    );

    assign Vdc1 = {prod1[PROD_W-1], prod1};
    assign Vdc2 = {prod2[PROD_W-1], prod2};

endmodule

// File: doc/adc_vdc_acq.md
Name: adc_vdc_acq

Overview:
- Upstream acquisition stage for the DAB converter top: reads both DC-link voltages from two 12-bit serial ADCs (shared SCLK/CS, separate data lines) once per switching period, on the `trigger` pulse from the modulator.
- Scales raw codes to signed fixed point Q20.17 (38 bits, 20 down to -17) and presents them as `Vdc1` and `Vdc2` to the controller.
- Flags over-voltage and trigger overrun for the protection logic.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period (>=1); SCLK = clk/(2*CLK_DIV).
- OFFSET, 0: ADC zero-code; unsigned 12 bit.
- GAIN_Q17, 12800: volts per LSB × 2^17; unsigned 24 bit; default = 400 V full scale over 4096 codes.
- VMAX_Q17, 45875200: over-voltage threshold in Q20.17; default = 350.0 V.

Ports:
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: reset.
- CE, in, 1: clock enable; when low, all state, counters and outputs hold.
- trigger, in, 1: one-cycle start pulse from the modulator.
- adc_sdata1, in, 1: serial data from the Vdc1 ADC.
- adc_sdata2, in, 1: serial data from the Vdc2 ADC.
- adc_sclk, out, 1: ADC serial clock; idles high.
- adc_cs_n, out, 1: ADC chip select; active low.
- Vdc1, out, 38 signed: Q20.17 primary DC-link voltage.
- Vdc2, out, 38 signed: Q20.17 secondary DC-link voltage.
- valid, out, 1: one-cycle pulse when Vdc1/Vdc2 update.
- busy, out, 1: high from trigger acceptance until the `valid` cycle inclusive.
- overrun, out, 1: sticky; a trigger arrived while busy.
- vdc_fault, out, 2: sticky over-voltage flags; [0] for Vdc1, [1] for Vdc2.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset state:
  - adc_cs_n=1, adc_sclk=1.
  - Vdc1=Vdc2=0.
  - valid=0, busy=0, overrun=0, vdc_fault=2'b00.
  - FSM in IDLE; shift registers and counters cleared.
  - Reset mid-frame aborts the transfer immediately. The next transfer starts only on a new trigger.
- All transitions below occur only on cycles with CE=1.
- FSM states: IDLE, SETUP, SHIFT, HOLD, SCALE, UPDATE.
- IDLE:
  - trigger=1 -> SETUP.
  - adc_cs_n falls on the same clock edge; busy rises.
- SETUP:
  - CLK_DIV cycles with adc_cs_n=0, adc_sclk=1, then -> SHIFT.
- SHIFT: 16 SCLK periods of 2*CLK_DIV cycles each.
  - adc_sclk low for the first half of each period, high for the second half.
  - Both sdata lines are sampled on the cycle where adc_sclk rises and shifted MSB-first into 16-bit registers.
  - After the 16th rising edge -> HOLD.
- HOLD:
  - adc_cs_n=1 for CLK_DIV cycles, then -> SCALE.
- SCALE (1 cycle):
  - code = sr[11:0]; sr[15:12] (leading zeros) are ignored.
  - diff = {1'b0,code} - OFFSET, 13-bit signed.
  - prod = diff × GAIN_Q17, 37-bit signed, registered.
  - No rounding and no saturation are needed; the result fits.
- UPDATE (1 cycle):
  - Vdc1/Vdc2 <= sign-extended prod.
  - valid=1.
  - vdc_fault[i] set if the new value > VMAX_Q17 (signed compare).
  - -> IDLE; busy falls on the following cycle.
- Latency: valid asserts 34*CLK_DIV+2 cycles after the trigger cycle (70 cycles at CLK_DIV=2).
- Trigger in any state other than IDLE, including the UPDATE cycle: ignored and overrun <= 1. The current frame continues unaffected.
- Trigger with CE=0: ignored, with no overrun.
- Vdc1/Vdc2 hold between updates.
- overrun and vdc_fault clear only on rst.

Decomposition:
- Shared package:
  - Q-format constants BITS_ENTEROS=20 and BITS_DECIMAL=17.
  - Derived width VDC_W=38.
  - ADC_FRAME_BITS=16, ADC_CODE_BITS=12.
  - FSM state encoding.
- One natural sub-module: adc_vdc_scale (offset subtract, multiply, compare).
  - Instantiated per channel.
  - Registered output, 1-cycle latency.

Test Plan:
- Nominal frame, defaults, ADC1 code 2048, ADC2 code 1024, single trigger:
  - valid at cycle 70.
  - Vdc1=26214400 (200.0 V), Vdc2=13107200 (100.0 V).
  - Exactly 16 SCLK rising edges; adc_cs_n low for 33*CLK_DIV cycles.
- Full-scale and fault, codes 4095 and 3600:
  - Vdc1=52416000 and Vdc2=46080000.
  - vdc_fault=2'b11, still set after later frames with code 0.
- Offset and negative result, OFFSET=100, code 50:
  - Vdc1=-640000 with correct 38-bit sign extension.
  - vdc_fault bit stays 0.
- Overrun, second trigger 20 cycles after the first:
  - Output values are from the first frame only; one valid pulse.
  - overrun=1.
  - A trigger on the UPDATE cycle also sets overrun.
- CE gating, CE low for 10 cycles mid-SHIFT:
  - adc_sclk/adc_cs_n frozen.
  - valid delayed exactly 10 cycles; values unchanged vs the nominal frame.
- Async reset mid-SHIFT:
  - adc_cs_n=1, adc_sclk=1 and busy=0 immediately, without waiting for a clk edge.
  - Vdc outputs 0.
  - A new trigger produces a correct frame.
